// File: rtl/ps2_keypad_if.sv
// rtl/ps2_keypad_if.sv - key-event valid/ready port of the PS/2 keypad receiver
interface ps2_keypad_if;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic       ev_release;
  logic       ev_ready;

  modport master (output ev_valid, ev_key, ev_release, input ev_ready);
  modport slave  (input ev_valid, ev_key, ev_release, output ev_ready);
endinterface

// File: rtl/ps2_keypad.sv
// rtl/ps2_keypad.sv - PS/2 Set-2 receiver to CHIP-8 keypad state plus event FIFO
// Optional PS2_EXT_EN: E0-prefixed arrow keys mapped onto keys 5/7/8/9.
module ps2_keypad #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [15:0]        input_keys,
  ps2_keypad_if.master       ev,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic               frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Returns {hit, key}; hit=0 means the code is not a keypad key.
  function automatic logic [4:0] map_std(input logic [7:0] code);
    case (code)
      8'h22: map_std = 5'h10;
      8'h16: map_std = 5'h11;
      8'h1E: map_std = 5'h12;
      8'h26: map_std = 5'h13;
      8'h15: map_std = 5'h14;
      8'h1D: map_std = 5'h15;
      8'h24: map_std = 5'h16;
      8'h1C: map_std = 5'h17;
      8'h1B: map_std = 5'h18;
      8'h23: map_std = 5'h19;
      8'h1A: map_std = 5'h1A;
      8'h21: map_std = 5'h1B;
      8'h25: map_std = 5'h1C;
      8'h2D: map_std = 5'h1D;
      8'h2B: map_std = 5'h1E;
      8'h2A: map_std = 5'h1F;
      default: map_std = 5'h00;
    endcase
  endfunction

  function automatic logic [4:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75: map_ext = 5'h15;
      8'h6B: map_ext = 5'h17;
      8'h72: map_ext = 5'h18;
      8'h74: map_ext = 5'h19;
      default: map_ext = 5'h00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [CW-1:0]          wd_q, wd_d;
  logic                   rel_pfx_q, rel_pfx_d;
  logic                   ext_pfx_q, ext_pfx_d;
  logic [15:0]            keys_q, keys_d;
  logic                   push_q, push_d;
  logic [4:0]             push_data_q, push_data_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]             mem_q [FIFO_DEPTH];
  logic [4:0]             mem_d [FIFO_DEPTH];

  logic       sample, data_s, timeout, byte_ok, is_ext_byte;
  logic [4:0] lookup;
  logic       empty, full, pop, do_push;

  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign sample  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != ST_IDLE) && (wd_q == WD_MAX);
  assign byte_ok = (^shift_q ^ parity_q) & data_s;
  assign lookup  = ext_pfx_q ? map_ext(shift_q) : map_std(shift_q);
`ifdef PS2_EXT_EN
  assign is_ext_byte = (shift_q == 8'hE0);
`else
  assign is_ext_byte = 1'b0;
`endif

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = ~empty & ev.ev_ready;
  assign do_push = push_q & (~full | pop);

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    rel_pfx_d   = rel_pfx_q;
    ext_pfx_d   = ext_pfx_q;
    keys_d      = keys_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;
    wd_d        = sample ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + CW'(1));

    // A stalled partial frame wins over any coincident sample.
    if (timeout) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      rel_pfx_d   = 1'b0;
      ext_pfx_d   = 1'b0;
    end else if (sample) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!byte_ok) begin
            frame_err_d = 1'b1;
            rel_pfx_d   = 1'b0;
            ext_pfx_d   = 1'b0;
          end else if (shift_q == 8'hF0) begin
            rel_pfx_d = 1'b1;
          end else if (is_ext_byte) begin
            ext_pfx_d = 1'b1;
          end else begin
            rel_pfx_d = 1'b0;
            ext_pfx_d = 1'b0;
            if (lookup[4] && (keys_q[lookup[3:0]] == rel_pfx_q)) begin
              keys_d[lookup[3:0]] = ~rel_pfx_q;
              push_d              = 1'b1;
              push_data_d         = {lookup[3:0], rel_pfx_q};
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data_q;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    if (clr_overflow) overflow_d = 1'b0;
    if (push_q && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      rel_pfx_q   <= 1'b0;
      ext_pfx_q   <= 1'b0;
      keys_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      wd_q        <= wd_d;
      rel_pfx_q   <= rel_pfx_d;
      ext_pfx_q   <= ext_pfx_d;
      keys_q      <= keys_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
    end
  end

  assign input_keys    = keys_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;
  assign ev.ev_valid   = ~empty;
  assign ev.ev_key     = mem_q[rptr_q[AW-1:0]][4:1];
  assign ev.ev_release = mem_q[rptr_q[AW-1:0]][0];

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

Parametrised PS/2 keyboard receiver for the CHIP-8 core, running entirely in the system clock domain. It oversamples the keyboard's clock and data lines, decodes Set-2 make/break frames into the 16-key CHIP-8 keypad state, and queues key-change events in a small FIFO. A watchdog recovers from truncated frames. The CPU consumes events through a valid/ready port.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on each PS/2 input; must be ≥2.
- `TIMEOUT_CYCLES`, default 2500: number of system clocks without a PS/2 falling edge before a partial frame is abandoned (100 µs at 25 MHz).
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two, ≥2.
- `clk  in  1`: system clock; all logic is on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `ps2_clk  in  1`: raw keyboard clock, asynchronous to `clk`.
- `ps2_data  in  1`: raw keyboard data, asynchronous to `clk`.
- `input_keys  out  16`: held state, one bit per CHIP-8 key 0x0–0xF.
- `ev_valid  out  1`: FIFO head holds an event.
- `ev_key  out  4`: CHIP-8 key of the head event.
- `ev_release  out  1`: 1 = break event, 0 = make event.
- `ev_ready  in  1`: pops the head when asserted together with `ev_valid`.
- `overflow  out  1`: sticky; an event was dropped.
- `clr_overflow  in  1`: synchronous clear of `overflow`.
- `frame_err  out  1`: one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- **Sampling.** Both inputs pass through `SYNC_STAGES` flops. A sample event is a synced `ps2_clk` transition 1→0, detected with one extra register. `ps2_data` is read from the synced value in the same cycle.
- **Frame FSM**, advancing one step per sample event:
  - IDLE: data=0 → DATA, bit index cleared. Data=1 → stay in IDLE.
  - DATA: 8 bits, LSB first. After bit 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: → IDLE. The byte is accepted only if odd parity holds (`^byte ^ parity == 1`) and stop=1. Otherwise `frame_err` pulses and the prefix flags are cleared.
- **Watchdog.** The watchdog counter clears on every sample event and saturates at `TIMEOUT_CYCLES`. If the FSM is not in IDLE and the count equals `TIMEOUT_CYCLES`, the FSM → IDLE, `frame_err` pulses and the prefix flags are cleared.
- **Byte decode**, performed on an accepted byte:
  - `F0` sets `rel_pfx`.
  - Any other byte is mapped, then both prefixes are cleared.
  - Map (Set-2 code → key): 22→0, 16→1, 1E→2, 26→3, 15→4, 1D→5, 24→6, 1C→7, 1B→8, 23→9, 1A→A, 21→B, 25→C, 2D→D, 2B→E, 2A→F. All other codes are unmapped and ignored.
- **Key update**, for a mapped key k:
  - `input_keys[k]` ← `~rel_pfx`.
  - An event {k, `rel_pfx`} is pushed only when the bit actually changes. Typematic repeats of a held key and breaks of an unheld key produce no event.
- **FIFO.**
  - A push while full is dropped and sets `overflow`. `input_keys` still updates.
  - A simultaneous push and pop on a full FIFO is accepted.
  - If `clr_overflow` and a new overflow coincide, `overflow` stays 1.
  - Pointers wrap modulo `FIFO_DEPTH`, with one extra bit used for full/empty detection.
- **Reset.** On `rst` the FSM goes to IDLE, counters, prefixes and FIFO are cleared, and the synchroniser stages are set to 1. A frame in progress is discarded. Reset values: `input_keys`=0, `ev_valid`=0, `ev_key`=0, `ev_release`=0, `overflow`=0, `frame_err`=0.

## Timing
- The synced edge is seen `SYNC_STAGES`+1 clocks after the pin edge.
- `input_keys` and the FIFO push take effect on the clock after the stop-bit sample event. `ev_valid` rises one clock later.
- `frame_err` asserts on the clock after the failing sample event or timeout, for exactly one clock.
- `ev_key` and `ev_release` are stable while `ev_valid`=1 and `ev_ready`=0. The pop is seen on the next clock.
- Throughput: one byte per 11 PS/2 clocks. Requires `clk` ≥ 8× `ps2_clk`.

## Configuration
- Macro: `PS2_EXT_EN`.
- **Defined:** an accepted `E0` byte sets `ext_pfx`. While `ext_pfx` is set, the byte map is replaced by the arrow map: 75(up)→5, 6B(left)→7, 72(down)→8, 74(right)→9. Other extended codes are ignored. `E0 F0 xx` produces a break.
- **Undefined:** `E0` is an unmapped byte and no extended prefix exists. `E0 75` is therefore ignored, because 75 is unmapped.

## Test plan
- Send 22 → `input_keys`=0x0001. Event {0, make}, `ev_valid`=1 until `ev_ready`.
- Send 22 a second time, then F0 22 → no event for the repeat. Then `input_keys`=0x0000 and event {0, release}.
- Send 1D with bad parity → `frame_err` pulses once, `input_keys` unchanged, no event.
- Send a start bit plus 4 data bits, then idle for 3000 clocks, then send 2A → `frame_err` at count 2500. Then `input_keys[15]`=1 and event {F, make}.
- With `ev_ready`=0, make 5 distinct keys → 4 events queued and `overflow`=1, while `input_keys` shows all 5 keys. `clr_overflow` → `overflow`=0.
- `PS2_EXT_EN` defined: E0 75, then E0 F0 75 → events {5, make} and {5, release}. Undefined: no events.
- `rst` mid-frame → all outputs 0. The next full frame (26) decodes to key 3.
